fft32_bitrev_reorder: RTL and testbench
=======================================

Name: fft32_bitrev_reorder

Overview:
Output-side reader for the 32-point radix-2 FFT datapath. The butterfly stages emit each 32-point frame as a serial stream in bit-reversed bin order. This block buffers each frame in ping-pong banks and re-emits it in natural bin order (bin 0..31), one complex sample per cycle. Valid/ready handshake on both sides; sustains 1 sample/cycle in steady state.

Parameters:
DATA_W, 32, width of each real/imag component (signed two's complement, same format as butterfly outputs)
N, 32, points per frame (fixed 32; the parameter exists only for width derivation)
LOG2N, 5, address width; must equal log2(N)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset
in_valid  input  1  input sample valid
in_ready  output  1  block can accept input sample
in_r  input  DATA_W  input real part, bit-reversed order
in_i  input  DATA_W  input imag part
in_last  input  1  marks 32nd sample of frame (checked only)
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts output
out_r  output  DATA_W  output real part, natural order
out_i  output  DATA_W  output imag part
out_idx  output  LOG2N  natural bin index of current output
out_last  output  1  high with bin 31
frame_err  output  1  sticky in_last framing error

Behaviour:
- Storage: two banks (B0, B1), each N x 2*DATA_W. Each bank has a full flag. A bank is written only while not full and read only while full.
- Reset (rst=0 at clk edge): both full flags 0; wbank=0, wcnt=0, rbank=0, rcnt=0; out_valid=0, out_r=0, out_i=0, out_idx=0, out_last=0, frame_err=0. Bank contents are not cleared. A reset mid-frame discards partial and buffered frames.
- Write side: in_ready = !full[wbank]. Accept when in_valid && in_ready.
  - Write mem[wbank][bitrev5(wcnt)] <= {in_r, in_i}; wcnt++.
  - On accepting wcnt==31: set full[wbank], toggle wbank, wcnt=0.
- Framing check: frame_err is set on accept when in_last != (wcnt==31). Framing uses the count only; in_last never alters wcnt.
- Read side: the output register loads when full[rbank] && (!out_valid || out_ready).
  - Load values: out_r/out_i <= mem[rbank][rcnt], out_idx <= rcnt, out_last <= (rcnt==31), out_valid <= 1; rcnt++.
  - Loading rcnt==31: clear full[rbank], toggle rbank, rcnt=0.
  - If out_valid && out_ready and no load: out_valid <= 0.
  - While out_valid && !out_ready, out_* hold stable.
- Latency: last input sample accepted at edge E -> first output (bin 0) valid after edge E+1. After that, one output per cycle while out_ready=1.
- Full/empty:
  - Both banks full -> in_ready=0 until the read side loads the last word of rbank. in_ready rises the cycle after that load.
  - No bank full -> out_valid falls after the pending word is taken.
- Simultaneous events: a write completing one bank and a read freeing the other bank in the same cycle both take effect. Flag updates target different banks, so there is no conflict. A write and a read never target the same bank.
- Arithmetic: none; data passes bit-exact (except under the optional feature).

Optional Feature:
Macro REORDER_CONJ_EN.
- Defined: out_i carries the negated stored imag part (complex conjugate), for IFFT via the conjugate trick. Negation saturates: -2^(DATA_W-1) maps to 2^(DATA_W-1)-1. out_r is unchanged.
- Undefined: out_i is bit-exact stored imag. No negation logic is present.

Test Plan:
- Reorder: one frame, sample k has in_r=k, in_i=-k, out_ready=1. Expect out_idx n carries out_r=bitrev5(n), e.g. idx1->16, idx2->8, idx3->24, idx31->31; out_last only at idx 31; frame_err=0.
- Back-to-back: 4 frames streamed continuously with out_ready=1. Expect in_ready stays 1, outputs contiguous after first latency, 128 outputs, frame order preserved.
- Backpressure: out_ready=0 while 3 frames are offered. Expect in_ready=0 after 64 accepts, out_* frozen at idx0. Then release out_ready: all 96 samples emerge in order with no loss or duplicate.
- Framing: in_last asserted on sample 15 of a frame. Expect frame_err=1 (sticky) and the frame is still output complete by count.
- Reset mid-operation: rst=0 after 20 inputs of frame 2 while frame 1 is being output. Expect out_valid=0, in_ready=1, and a new frame afterwards outputs correctly from idx 0.
- REORDER_CONJ_EN defined: in_i=-2^31 and in_i=5. Expect out_i=2^31-1 and out_i=-5 respectively.

Source files
------------

// File: rtl/fft32_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft32_bitrev_reorder
//
// Output-side reader for the 32-point radix-2 FFT datapath. The butterfly
// stages deliver each frame in bit-reversed bin order. This block stores every
// frame in one of two ping-pong banks, scattering each sample to its
// bit-reversed address. It then replays the bank linearly, so frames leave in
// natural bin order (0..31) at one complex sample per cycle.
//
// Optional build macro: REORDER_CONJ_EN
//   defined   : out_i carries the saturated negation of the stored imag part
//               (complex conjugate, for IFFT via the conjugate trick).
//   undefined : out_i is the stored imag part, bit-exact.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   input sample valid
//   in_ready   input sample can be accepted (write bank not full)
//   in_r/in_i  input real/imag, bit-reversed order, signed DATA_W
//   in_last    marks 32nd sample of a frame; used only for the framing flag
//   out_valid  output sample valid
//   out_ready  downstream accepts output
//   out_r/out_i output real/imag, natural order, signed DATA_W
//   out_idx    natural bin index of the current output
//   out_last   high with bin N-1
//   frame_err  sticky: in_last disagreed with the internal sample count
// ---------------------------------------------------------------------------
module fft32_bitrev_reorder #(
  parameter int DATA_W = 32,
  parameter int N      = 32,
  parameter int LOG2N  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i,
  output logic [LOG2N-1:0]         out_idx,
  output logic                     out_last,
  output logic                     frame_err
);

  localparam int MEM_W = 2 * DATA_W;
  localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(N - 1);

  // Reverse the address bits: sample k of the bit-reversed stream belongs to
  // natural bin bitrev(k).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

`ifdef REORDER_CONJ_EN
  // Two's-complement negation with saturation: the most negative value has
  // no positive counterpart, so it maps to the most positive one.
  function automatic logic signed [DATA_W-1:0] neg_sat(
    input logic signed [DATA_W-1:0] v
  );
    logic signed [DATA_W-1:0] most_neg;
    most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    if (v == most_neg) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    return -v;
  endfunction
`endif

  // Ping-pong storage; contents are never reset.
  logic [MEM_W-1:0] mem [2][N];

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wbank;
  logic             rbank;
  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;

  logic             wr_en;
  logic             wr_done;
  logic             rd_load;
  logic             rd_done;

  logic [MEM_W-1:0]         rd_word_p0;
  logic signed [DATA_W-1:0] rd_r_p0;
  logic signed [DATA_W-1:0] rd_i_p0;
  logic signed [DATA_W-1:0] rd_i_fmt_p0;

  assign in_ready = !full[wbank];
  assign wr_en    = in_valid && in_ready;
  assign wr_done  = wr_en && (wcnt == LAST_CNT);

  // The output register refills when a full bank is waiting and the current
  // word is either absent or being taken this cycle.
  assign rd_load  = full[rbank] && (!out_valid || out_ready);
  assign rd_done  = rd_load && (rcnt == LAST_CNT);

  // A write only ever completes a non-full bank and a read only ever drains a
  // full one, so the two updates always land on different banks.
  always_comb begin
    full_nxt = full;
    if (wr_done) begin
      full_nxt[wbank] = 1'b1;
    end
    if (rd_done) begin
      full_nxt[rbank] = 1'b0;
    end
  end

  // ---- stage p0: scatter write into the write bank ----
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wbank][bitrev(wcnt)] <= {in_r, in_i};
    end
  end

  // ---- stage p0: linear fetch from the read bank ----
  assign rd_word_p0 = mem[rbank][rcnt];
  assign rd_r_p0    = rd_word_p0[MEM_W-1:DATA_W];
  assign rd_i_p0    = rd_word_p0[DATA_W-1:0];

`ifdef REORDER_CONJ_EN
  assign rd_i_fmt_p0 = neg_sat(rd_i_p0);
`else
  assign rd_i_fmt_p0 = rd_i_p0;
`endif

  // ---- stage p1: bank bookkeeping and framing flag ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      full      <= 2'b00;
      wbank     <= 1'b0;
      wcnt      <= '0;
      rbank     <= 1'b0;
      rcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      full <= full_nxt;

      if (wr_en) begin
        // Framing follows the count alone; in_last only raises the flag.
        if (in_last != (wcnt == LAST_CNT)) begin
          frame_err <= 1'b1;
        end
        if (wr_done) begin
          wcnt  <= '0;
          wbank <= !wbank;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      if (rd_load) begin
        if (rd_done) begin
          rcnt  <= '0;
          rbank <= !rbank;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (rd_load) begin
      out_valid <= 1'b1;
      out_r     <= rd_r_p0;
      out_i     <= rd_i_fmt_p0;
      out_idx   <= rcnt;
      out_last  <= (rcnt == LAST_CNT);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft32_bitrev_reorder.sv
module tb_fft32_bitrev_reorder;

  localparam int DATA_W = 32;
  localparam int N      = 32;
  localparam int LOG2N  = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_r;
  logic signed [DATA_W-1:0] in_i;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_r;
  logic signed [DATA_W-1:0] out_i;
  logic [LOG2N-1:0]         out_idx;
  logic                     out_last;
  logic                     frame_err;

  fft32_bitrev_reorder #(.DATA_W(DATA_W), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last),
    .frame_err(frame_err)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepts = 0;
  int stalls = 0;
  int pops = 0;
  int mark_pop = -1;
  int first_cyc = 0;
  int last_cyc = 0;

  logic [69:0] sb[$];
  logic signed [DATA_W-1:0] fr_r [N];
  logic signed [DATA_W-1:0] fr_i [N];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int brev5(input int n);
    int r = 0;
    for (int b = 0; b < 5; b++) if (n & (1 << b)) r |= (1 << (4 - b));
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] model_i(input logic signed [DATA_W-1:0] v);
`ifdef REORDER_CONJ_EN
    if (v == 32'sh8000_0000) return 32'sh7fff_ffff;
    return -v;
`else
    return v;
`endif
  endfunction

  task automatic fill(input int base);
    for (int k = 0; k < N; k++) begin
      fr_r[k] = base + k;
      fr_i[k] = -(base + k);
    end
  endtask

  task automatic push_frame();
    for (int n = 0; n < N; n++) begin
      int k;
      k = brev5(n);
      sb.push_back({fr_r[k], model_i(fr_i[k]), 5'(n), (n == N - 1)});
    end
  endtask

  // Drives nsamp samples of the frame in fr_r/fr_i; in_last at last_at.
  task automatic send_frame(input int last_at, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      int g;
      g = 0;
      in_valid = 1'b1;
      in_r     = fr_r[k];
      in_i     = fr_i[k];
      in_last  = (k == last_at);
      while (!in_ready && g < 2000) begin
        stalls++;
        g++;
        @(posedge clk); #1;
      end
      if (g >= 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready observed 0 expected 1 at sample %0d", k);
      end
      @(posedge clk); #1;
      accepts++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (nsamp == N) push_frame();
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (sb.size() > 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_drain_left"}, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Scoreboard monitor: a transfer happens at the next rising edge whenever
  // out_valid && out_ready hold mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed idx %0d with scoreboard empty", out_idx);
      end
      if (sb.size() > 0) begin
        logic [69:0] e;
        e = sb.pop_front();
        chk("out_word", {out_r, out_i, out_idx, out_last}, e);
      end
      if (pops == mark_pop) first_cyc = cyc;
      last_cyc = cyc;
      pops++;
    end
  end

  initial begin
    int p0;
    int a0;
    rst = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, in_ready, out_idx, out_last, frame_err, out_r, out_i},
        {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0});
    rst = 1'b1;
    @(posedge clk); #1;

    // Reorder: sample k carries (k, -k)
    fill(0);
    send_frame(31, 32);
    @(posedge clk); #1;
    chk("first_latency", {out_valid, out_idx, out_r}, {1'b1, 5'd0, 32'd0});
    @(posedge clk); #1;
    chk("reorder_idx1", {out_idx, out_r}, {5'd1, 32'd16});
    @(posedge clk); #1;
    chk("reorder_idx2", {out_idx, out_r}, {5'd2, 32'd8});
    drain("reorder");
    chk("reorder_ferr", frame_err, 0);

    // Back-to-back: 4 frames, no stalls, contiguous output
    stalls = 0;
    p0 = pops;
    mark_pop = pops;
    for (int f = 1; f <= 4; f++) begin
      fill(f * 256);
      send_frame(31, 32);
    end
    drain("b2b");
    chk("b2b_stalls", stalls, 0);
    chk("b2b_count", pops - p0, 128);
    chk("b2b_contig", last_cyc - first_cyc, 127);

    // Backpressure: 3 frames offered while out_ready is low
    out_ready = 1'b0;
    p0 = pops;
    a0 = accepts;
    fork
      begin
        for (int f = 10; f <= 12; f++) begin
          fill(f * 256);
          send_frame(31, 32);
        end
      end
      begin
        int g = 0;
        while ((accepts - a0) < 64 && g < 500) begin
          @(posedge clk); #1;
          g++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accepts", accepts - a0, 64);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_a", {out_valid, out_idx, out_r, out_i},
            {1'b1, 5'd0, 32'd2560, model_i(-32'sd2560)});
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_b", {out_valid, out_idx, out_r}, {1'b1, 5'd0, 32'd2560});
        out_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_count", pops - p0, 96);

    // Framing: in_last on sample 15
    chk("frame_ok_before", frame_err, 0);
    fill(20 * 256);
    send_frame(15, 32);
    #1;
    chk("frame_err_set", frame_err, 1);
    drain("framing");
    fill(21 * 256);
    send_frame(31, 32);
    drain("framing2");
    chk("frame_err_sticky", frame_err, 1);

    // Reset mid-operation
    fill(30 * 256);
    send_frame(31, 32);
    fill(31 * 256);
    send_frame(31, 20);
    chk("rst_midout", out_valid, 1);
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("rst_mid_state", {out_valid, in_ready, frame_err, out_idx}, {1'b0, 1'b1, 1'b0, 5'd0});
    rst = 1'b1;
    @(posedge clk); #1;
    fill(32 * 256);
    send_frame(31, 32);
    @(posedge clk); #1;
    chk("rst_new_idx0", {out_valid, out_idx, out_r}, {1'b1, 5'd0, 32'd8192});
    drain("after_rst");

    // Extreme imag values (conjugated and saturated when enabled)
    fill(40 * 256);
    fr_i[0] = 32'sh8000_0000;
    fr_i[1] = 32'sd5;
    send_frame(31, 32);
    @(posedge clk); #1;
    chk("extreme_idx0_i", {out_idx, out_i}, {5'd0, model_i(32'sh8000_0000)});
    drain("extreme");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
